// File: rtl/bus_dev_port.sv
// rtl/bus_dev_port.sv - bus device port: FWFT TX queue to arbiter, address-filtered FWFT RX queue
module bus_dev_port #(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'd0,
  parameter logic [7:0] broadcast = 8'b1000_1111
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [pckg_sz-1:0]         wr_data,
  output logic                       tx_full,
  output logic [$clog2(depth):0]     tx_count,
  output logic                       pndng,
  input  logic                       pop,
  output logic [pckg_sz-1:0]         D_pop,
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  input  logic                       rx_rd,
  output logic [pckg_sz-1:0]         rx_data,
  output logic                       rx_valid,
  output logic                       ovf_tx,
  output logic                       udf_tx,
  output logic                       ovf_rx,
  output logic [7:0]                 misroute_cnt
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Storage arrays (contents survive reset; only pointers/counts matter)
  logic [pckg_sz-1:0] tx_mem_q [depth];
  logic [pckg_sz-1:0] rx_mem_q [depth];

  // TX queue state
  logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [AW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [CW-1:0] tx_count_q,  tx_count_d;
  logic          ovf_tx_q,    ovf_tx_d;
  logic          udf_tx_q,    udf_tx_d;

  // RX queue state
  logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [AW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CW-1:0] rx_count_q,  rx_count_d;
  logic          ovf_rx_q,    ovf_rx_d;
  logic [7:0]    misroute_cnt_q, misroute_cnt_d;

  // Qualified transfer strobes
  logic tx_empty, tx_full_w, tx_pop_ok, tx_wr_ok;
  logic rx_empty, rx_full_w, rx_rd_ok, rx_wr_ok, dest_match;

  // TX queue: accept writes unless full (a same-cycle pop frees a slot), flag misuse
  always_comb begin
    tx_empty    = (tx_count_q == '0);
    tx_full_w   = (tx_count_q == DEPTH_C);
    tx_pop_ok   = pop & ~tx_empty;
    tx_wr_ok    = wr_en & (~tx_full_w | tx_pop_ok);
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_count_d  = tx_count_q;
    ovf_tx_d    = ovf_tx_q;
    udf_tx_d    = udf_tx_q;
    if (tx_wr_ok) begin
      tx_wr_ptr_d = tx_wr_ptr_q + PTR_ONE;
    end
    if (tx_pop_ok) begin
      tx_rd_ptr_d = tx_rd_ptr_q + PTR_ONE;
    end
    case ({tx_wr_ok, tx_pop_ok})
      2'b10:   tx_count_d = tx_count_q + CNT_ONE;
      2'b01:   tx_count_d = tx_count_q - CNT_ONE;
      default: tx_count_d = tx_count_q;
    endcase
    if (wr_en && tx_full_w && !pop) begin
      ovf_tx_d = 1'b1;
    end
    if (pop && tx_empty) begin
      udf_tx_d = 1'b1;
    end
  end

  // RX queue: filter on destination byte, accept if room (a same-cycle read frees a slot)
  always_comb begin
    dest_match     = (D_push[pckg_sz-1 -: 8] == id) || (D_push[pckg_sz-1 -: 8] == broadcast);
    rx_empty       = (rx_count_q == '0);
    rx_full_w      = (rx_count_q == DEPTH_C);
    rx_rd_ok       = rx_rd & ~rx_empty;
    rx_wr_ok       = push & dest_match & (~rx_full_w | rx_rd_ok);
    rx_wr_ptr_d    = rx_wr_ptr_q;
    rx_rd_ptr_d    = rx_rd_ptr_q;
    rx_count_d     = rx_count_q;
    ovf_rx_d       = ovf_rx_q;
    misroute_cnt_d = misroute_cnt_q;
    if (rx_wr_ok) begin
      rx_wr_ptr_d = rx_wr_ptr_q + PTR_ONE;
    end
    if (rx_rd_ok) begin
      rx_rd_ptr_d = rx_rd_ptr_q + PTR_ONE;
    end
    case ({rx_wr_ok, rx_rd_ok})
      2'b10:   rx_count_d = rx_count_q + CNT_ONE;
      2'b01:   rx_count_d = rx_count_q - CNT_ONE;
      default: rx_count_d = rx_count_q;
    endcase
    if (push && dest_match && rx_full_w && !rx_rd_ok) begin
      ovf_rx_d = 1'b1;
    end
    if (push && !dest_match && (misroute_cnt_q != 8'hFF)) begin
      misroute_cnt_d = misroute_cnt_q + 8'd1;
    end
  end

  // Control state register with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr_ptr_q    <= '0;
      tx_rd_ptr_q    <= '0;
      tx_count_q     <= '0;
      ovf_tx_q       <= 1'b0;
      udf_tx_q       <= 1'b0;
      rx_wr_ptr_q    <= '0;
      rx_rd_ptr_q    <= '0;
      rx_count_q     <= '0;
      ovf_rx_q       <= 1'b0;
      misroute_cnt_q <= '0;
    end else begin
      tx_wr_ptr_q    <= tx_wr_ptr_d;
      tx_rd_ptr_q    <= tx_rd_ptr_d;
      tx_count_q     <= tx_count_d;
      ovf_tx_q       <= ovf_tx_d;
      udf_tx_q       <= udf_tx_d;
      rx_wr_ptr_q    <= rx_wr_ptr_d;
      rx_rd_ptr_q    <= rx_rd_ptr_d;
      rx_count_q     <= rx_count_d;
      ovf_rx_q       <= ovf_rx_d;
      misroute_cnt_q <= misroute_cnt_d;
    end
  end

  // Packet storage writes at the tail slot of each queue
  always_ff @(posedge clk) begin
    if (tx_wr_ok) begin
      tx_mem_q[tx_wr_ptr_q] <= wr_data;
    end
    if (rx_wr_ok) begin
      rx_mem_q[rx_wr_ptr_q] <= D_push;
    end
  end

  // Fall-through heads are forced to zero when empty, so reset clears them at once
  assign pndng        = ~tx_empty;
  assign tx_full      = tx_full_w;
  assign tx_count     = tx_count_q;
  assign D_pop        = tx_empty ? '0 : tx_mem_q[tx_rd_ptr_q];
  assign rx_valid     = ~rx_empty;
  assign rx_data      = rx_empty ? '0 : rx_mem_q[rx_rd_ptr_q];
  assign ovf_tx       = ovf_tx_q;
  assign udf_tx       = udf_tx_q;
  assign ovf_rx       = ovf_rx_q;
  assign misroute_cnt = misroute_cnt_q;

endmodule

// File: tb/tb_bus_dev_port.sv
// tb/tb_bus_dev_port.sv - directed self-checking bench for bus_dev_port
module tb_bus_dev_port;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        tx_full;
  logic [3:0]  tx_count;
  logic        pndng;
  logic        pop;
  logic [15:0] D_pop;
  logic        push;
  logic [15:0] D_push;
  logic        rx_rd;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        ovf_tx;
  logic        udf_tx;
  logic        ovf_rx;
  logic [7:0]  misroute_cnt;

  int checks = 0;
  int errors = 0;

  bus_dev_port #(
    .pckg_sz(16),
    .depth(8),
    .id(8'd3),
    .broadcast(8'h8F)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .tx_full(tx_full),
    .tx_count(tx_count),
    .pndng(pndng),
    .pop(pop),
    .D_pop(D_pop),
    .push(push),
    .D_push(D_push),
    .rx_rd(rx_rd),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .ovf_tx(ovf_tx),
    .udf_tx(udf_tx),
    .ovf_rx(ovf_rx),
    .misroute_cnt(misroute_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    pop     = 1'b0;
    push    = 1'b0;
    D_push  = '0;
    rx_rd   = 1'b0;
    step();
    step();
    chk("rst_tx_count", 32'(tx_count), 32'd0);
    chk("rst_pndng",    32'(pndng),    32'd0);
    chk("rst_tx_full",  32'(tx_full),  32'd0);
    chk("rst_D_pop",    32'(D_pop),    32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data",  32'(rx_data),  32'd0);
    chk("rst_flags",    32'({ovf_tx, udf_tx, ovf_rx}), 32'd0);
    chk("rst_misroute", 32'(misroute_cnt), 32'd0);
    reset = 1'b1;

    // two writes, FWFT latency of one cycle
    wr_en = 1'b1; wr_data = 16'h0A11;
    step();
    chk("fwft_pndng", 32'(pndng), 32'd1);
    chk("fwft_D_pop", 32'(D_pop), 32'h0A11);
    wr_data = 16'h0A22;
    step();
    wr_en = 1'b0;
    chk("two_count", 32'(tx_count), 32'd2);
    chk("two_head",  32'(D_pop),    32'h0A11);
    pop = 1'b1;
    step();
    chk("pop1_head",  32'(D_pop),    32'h0A22);
    chk("pop1_count", 32'(tx_count), 32'd1);
    step();
    pop = 1'b0;
    chk("pop2_pndng", 32'(pndng), 32'd0);
    chk("pop2_D_pop", 32'(D_pop), 32'd0);
    chk("pop2_udf",   32'(udf_tx), 32'd0);

    // fill eight (pointers start at 2, so the drain wraps), then overflow
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 16'h0B00 + 16'(i);
      step();
    end
    chk("fill_full",  32'(tx_full),  32'd1);
    chk("fill_count", 32'(tx_count), 32'd8);
    chk("fill_ovf0",  32'(ovf_tx),   32'd0);
    wr_data = 16'h0BFF;
    step();
    wr_en = 1'b0;
    chk("ovf_flag",  32'(ovf_tx),   32'd1);
    chk("ovf_count", 32'(tx_count), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_%0d", i), 32'(D_pop), 32'(16'h0B00 + 16'(i)));
      pop = 1'b1;
      step();
    end
    pop = 1'b0;
    chk("drain_pndng", 32'(pndng), 32'd0);
    chk("drain_D_pop", 32'(D_pop), 32'd0);
    chk("ovf_sticky",  32'(ovf_tx), 32'd1);

    // underflow
    pop = 1'b1;
    step();
    pop = 1'b0;
    chk("udf_flag",  32'(udf_tx),   32'd1);
    chk("udf_count", 32'(tx_count), 32'd0);

    // RX filtering: own id, broadcast, foreign id
    push = 1'b1; D_push = 16'h03AB;
    step();
    chk("rx_valid1", 32'(rx_valid), 32'd1);
    chk("rx_head1",  32'(rx_data),  32'h03AB);
    D_push = 16'h8F01;
    step();
    D_push = 16'h05CC;
    step();
    push = 1'b0;
    chk("misroute1", 32'(misroute_cnt), 32'd1);
    chk("rx_head_keep", 32'(rx_data), 32'h03AB);
    rx_rd = 1'b1;
    step();
    chk("rx_head2", 32'(rx_data), 32'h8F01);
    step();
    rx_rd = 1'b0;
    chk("rx_empty_valid", 32'(rx_valid), 32'd0);
    chk("rx_empty_data",  32'(rx_data),  32'd0);
    rx_rd = 1'b1;
    step();
    rx_rd = 1'b0;
    chk("rx_rd_empty", 32'(rx_valid), 32'd0);

    // RX overflow, then push with simultaneous read while full
    for (int i = 1; i <= 8; i++) begin
      push = 1'b1; D_push = 16'h0300 + 16'(i);
      step();
    end
    chk("rx_fill_ovf0", 32'(ovf_rx), 32'd0);
    D_push = 16'h0399;
    step();
    chk("rx_ovf",      32'(ovf_rx),  32'd1);
    chk("rx_ovf_head", 32'(rx_data), 32'h0301);
    D_push = 16'h03EE; rx_rd = 1'b1;
    step();
    push = 1'b0; rx_rd = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      chk($sformatf("rx_drain_%0d", i), 32'(rx_data), 32'(16'h0300 + 16'(i)));
      rx_rd = 1'b1;
      step();
    end
    chk("rx_drain_last", 32'(rx_data), 32'h03EE);
    step();
    rx_rd = 1'b0;
    chk("rx_drain_done", 32'(rx_valid), 32'd0);

    // misroute saturation
    push = 1'b1; D_push = 16'h0500;
    repeat (300) step();
    push = 1'b0;
    chk("misroute_sat", 32'(misroute_cnt), 32'd255);

    // leave an RX packet pending, queue three TX packets, then reset between edges
    push = 1'b1; D_push = 16'h0377;
    step();
    push = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      wr_en = 1'b1; wr_data = 16'h0D00 + 16'(i);
      step();
    end
    wr_en = 1'b0;
    chk("pre_rst_count", 32'(tx_count), 32'd3);
    reset = 1'b0;
    #2;
    chk("async_count",    32'(tx_count), 32'd0);
    chk("async_pndng",    32'(pndng),    32'd0);
    chk("async_D_pop",    32'(D_pop),    32'd0);
    chk("async_rx_valid", 32'(rx_valid), 32'd0);
    chk("async_rx_data",  32'(rx_data),  32'd0);
    chk("async_flags",    32'({ovf_tx, udf_tx, ovf_rx}), 32'd0);
    chk("async_misroute", 32'(misroute_cnt), 32'd0);
    reset = 1'b1;
    wr_en = 1'b1; wr_data = 16'h0E55;
    step();
    wr_en = 1'b0;
    chk("post_rst_D_pop", 32'(D_pop),    32'h0E55);
    chk("post_rst_count", 32'(tx_count), 32'd1);

    // write with pop while empty: write kept, underflow flagged
    pop = 1'b1;
    step();
    wr_en = 1'b1; wr_data = 16'h0E66;
    chk("udf_clear", 32'(udf_tx), 32'd0);
    step();
    wr_en = 1'b0; pop = 1'b0;
    chk("wp_empty_udf",   32'(udf_tx),   32'd1);
    chk("wp_empty_D_pop", 32'(D_pop),    32'h0E66);
    chk("wp_empty_count", 32'(tx_count), 32'd1);

    // write with pop while full: both happen, count holds, no overflow
    for (int i = 1; i <= 7; i++) begin
      wr_en = 1'b1; wr_data = 16'h0E70 + 16'(i);
      step();
    end
    chk("wp_full_pre", 32'(tx_full), 32'd1);
    wr_data = 16'h0EAA; pop = 1'b1;
    step();
    wr_en = 1'b0; pop = 1'b0;
    chk("wp_full_count", 32'(tx_count), 32'd8);
    chk("wp_full_ovf",   32'(ovf_tx),   32'd0);
    chk("wp_full_head",  32'(D_pop),    32'h0E71);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
